queue: RTL and testbench
========================

Name: queue

Overview:
- Synchronous circular FIFO queue. Companion to the team's LIFO stack: same push/pop port style, opposite ordering.
- Data is popped in the order it was pushed.
- Used as a small buffer between producers and consumers inside a single clock domain.
- Adds full/empty flags, an occupancy count and sticky overflow/underflow error flags.

Parameters:
- QUEUE_WIDTH, 18, bit width of each stored word.
- QUEUE_DEPTH_LOG2, 4, log2 of the number of entries (default 16 entries); minimum 1.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_push  input  1  write i_data at the tail this cycle.
- i_pop  input  1  read the head word this cycle.
- i_data  input  QUEUE_WIDTH  data to push.
- o_data  output  QUEUE_WIDTH  registered head word from the most recent accepted pop.
- o_valid  output  1  one-cycle pulse: o_data was updated by an accepted pop.
- o_empty  output  1  registered; count == 0.
- o_full  output  1  registered; count == 2^QUEUE_DEPTH_LOG2.
- o_count  output  QUEUE_DEPTH_LOG2+1  registered occupancy.
- o_overflow  output  1  sticky; a push was dropped.
- o_underflow  output  1  sticky; a pop was refused.

Behaviour:
- Reset values: rd_ptr=0, wr_ptr=0, o_count=0, o_data=0, o_valid=0, o_empty=1, o_full=0, o_overflow=0, o_underflow=0. Memory contents are not reset.
- Pointers are QUEUE_DEPTH_LOG2 bits wide. They wrap naturally from 2^N-1 to 0, with no extra logic.
- Accepted pop requires i_pop && !o_empty. On an accepted pop:
  - o_data <= mem[rd_ptr].
  - rd_ptr increments.
  - o_valid=1 in the following cycle.
  - Pop-to-data latency is 1 cycle.
- Refused pop (i_pop && o_empty): o_underflow <= 1, o_data holds, o_valid=0, pointers unchanged.
- Accepted push requires i_push && (!o_full || accepted pop in the same cycle). On an accepted push, mem[wr_ptr] <= i_data and wr_ptr increments.
- Dropped push (i_push && o_full && !i_pop): o_overflow <= 1, memory and pointers unchanged.
- Push and pop in the same cycle:
  - Not empty: both accepted, count unchanged. This holds when full too (the slot is freed and refilled).
  - Empty: push accepted, pop refused (underflow set). There is no fall-through, so the new word appears only on a later pop.
- Count update: +1 on accepted push only, -1 on accepted pop only, unchanged otherwise. o_empty and o_full are derived from the next count and registered, so they are valid in the same cycle as o_count.
- Sticky flags clear only on i_rst.
- Reset takes priority over push and pop in the same cycle. A reset mid-stream discards all contents, and the first pop after reset is refused.
- Invariants, to be checked formally under `ifdef FORMAL`:
  - o_count <= 2^N.
  - (wr_ptr - rd_ptr) mod 2^N == o_count[N-1:0].
  - o_full and o_empty are never both set.

Decomposition:
- No shared package. Pointer width and depth are localparams computed from QUEUE_DEPTH_LOG2.
- One natural sub-module: sdp_ram, a simple dual-port RAM with 1 write port and 1 registered read port of QUEUE_WIDTH x 2^N. It lets synthesis infer block/distributed RAM. The queue instantiates sdp_ram and holds all pointer/flag control.

Test Plan:
- Reset, then push 0x00A, 0x00B, 0x00C on consecutive cycles, then pop x3 -> o_data 0x00A, 0x00B, 0x00C on the cycles after each pop; o_valid high each of those cycles; o_count 3→0; o_empty=1 at the end.
- QUEUE_DEPTH_LOG2=2: push 5 words 1..5 -> o_full=1 after the 4th push; the 5th push is dropped and o_overflow=1; popping 4 times yields 1,2,3,4.
- Pop on an empty queue after reset -> o_underflow=1, o_valid=0, o_data stays 0, o_count stays 0.
- QUEUE_DEPTH_LOG2=2, full with 1..4: push 9 and pop in the same cycle -> o_data=1, o_count stays 4, no overflow. Then pop x4 -> 2,3,4,9, showing write and read pointer wrap.
- Empty queue, push 0x3FFFF and pop in the same cycle -> o_underflow=1, o_count=1. The next pop gives o_data=0x3FFFF.
- Push 2 words, assert i_rst together with i_pop -> next cycle o_count=0, o_empty=1, o_data=0, o_valid=0, sticky flags cleared.

Source files
------------

// File: rtl/queue_if.sv
// Handshake bundle between a producer/consumer and the queue.
// The queue uses the slave modport; the driving side uses master.
interface queue_if #(
    parameter int QUEUE_WIDTH      = 18,
    parameter int QUEUE_DEPTH_LOG2 = 4
);
    logic                      i_push;
    logic                      i_pop;
    logic [QUEUE_WIDTH-1:0]    i_data;
    logic [QUEUE_WIDTH-1:0]    o_data;
    logic                      o_valid;
    logic                      o_empty;
    logic                      o_full;
    logic [QUEUE_DEPTH_LOG2:0] o_count;
    logic                      o_overflow;
    logic                      o_underflow;

    modport slave (
        input  i_push, i_pop, i_data,
        output o_data, o_valid, o_empty, o_full, o_count, o_overflow, o_underflow
    );

    modport master (
        output i_push, i_pop, i_data,
        input  o_data, o_valid, o_empty, o_full, o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/queue_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The read register resets to zero so the queue's data output has a defined reset value.
module sdp_ram #(
    parameter int WIDTH  = 18,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port; storage is intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-first registered read so a same-address write returns the old word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/queue.sv
// Synchronous circular FIFO with registered flags, occupancy and sticky errors.
// All pointer/flag control lives here; storage is in sdp_ram.
module queue #(
    parameter int QUEUE_WIDTH      = 18,
    parameter int QUEUE_DEPTH_LOG2 = 4
) (
    input  logic    i_clk,
    input  logic    i_rst,
    queue_if.slave  q
);
    localparam int PTR_W = QUEUE_DEPTH_LOG2;
    localparam int CNT_W = QUEUE_DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH = {1'b1, {PTR_W{1'b0}}};

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Acceptance: a push into a full queue is allowed when a pop frees the slot.
    always_comb begin
        pop_ok_s  = q.i_pop && !empty_q;
        push_ok_s = q.i_push && (!full_q || pop_ok_s);
    end

    // Next-state for pointers, occupancy, flags and error bits.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + CNT_W'(1'b1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_d = count_q - CNT_W'(1'b1);
        end else begin
            count_d = count_q;
        end
        empty_d = (count_d == {CNT_W{1'b0}});
        full_d  = (count_d == DEPTH);
        valid_d = pop_ok_s;
        ovf_d   = ovf_q | (q.i_push && !push_ok_s);
        unf_d   = unf_q | (q.i_pop && !pop_ok_s);
    end

    // State registers; reset wins over any same-cycle push or pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    sdp_ram #(
        .WIDTH  (QUEUE_WIDTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .we_i    (push_ok_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (q.i_data),
        .re_i    (pop_ok_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (q.o_data)
    );

    assign q.o_valid     = valid_q;
    assign q.o_empty     = empty_q;
    assign q.o_full      = full_q;
    assign q.o_count     = count_q;
    assign q.o_overflow  = ovf_q;
    assign q.o_underflow = unf_q;

`ifdef FORMAL
    // Structural invariants between pointers, occupancy and flags.
    always @(posedge i_clk) begin
        if (!i_rst) begin
            assert (count_q <= DEPTH);
            assert (PTR_W'(wr_ptr_q - rd_ptr_q) == count_q[PTR_W-1:0]);
            assert (!(full_q && empty_q));
        end
    end
`endif
endmodule

// File: tb/tb_queue.sv
// Directed bench for queue at depth 4 (QUEUE_DEPTH_LOG2=2), 18-bit words.
module tb_queue;
    localparam int W  = 18;
    localparam int LG = 2;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    queue_if #(.QUEUE_WIDTH(W), .QUEUE_DEPTH_LOG2(LG)) qi ();

    queue #(.QUEUE_WIDTH(W), .QUEUE_DEPTH_LOG2(LG)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .q     (qi.slave)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given inputs; returns 1 time unit after the edge.
    task automatic step(input logic rst, input logic push, input logic pop, input logic [W-1:0] d);
        i_rst     = rst;
        qi.i_push = push;
        qi.i_pop  = pop;
        qi.i_data = d;
        @(posedge i_clk);
        #1;
        i_rst     = 1'b0;
        qi.i_push = 1'b0;
        qi.i_pop  = 1'b0;
    endtask

    task automatic check_pop(input string tag, input logic [W-1:0] d, input int cnt);
        check({tag, "_data"}, 32'(qi.o_data), 32'(d));
        check({tag, "_valid"}, 32'(qi.o_valid), 32'd1);
        check({tag, "_count"}, 32'(qi.o_count), 32'(cnt));
    endtask

    initial begin
        qi.i_push = 1'b0;
        qi.i_pop  = 1'b0;
        qi.i_data = '0;
        step(1'b1, 1'b0, 1'b0, 18'h0);
        step(1'b1, 1'b0, 1'b0, 18'h0);

        check("rst_count", 32'(qi.o_count), 32'd0);
        check("rst_empty", 32'(qi.o_empty), 32'd1);
        check("rst_full", 32'(qi.o_full), 32'd0);
        check("rst_data", 32'(qi.o_data), 32'd0);
        check("rst_valid", 32'(qi.o_valid), 32'd0);
        check("rst_ovf", 32'(qi.o_overflow), 32'd0);
        check("rst_unf", 32'(qi.o_underflow), 32'd0);

        // Basic ordering: push A,B,C then pop three times.
        step(1'b0, 1'b1, 1'b0, 18'h0000A);
        check("t1_cnt1", 32'(qi.o_count), 32'd1);
        check("t1_nempty", 32'(qi.o_empty), 32'd0);
        step(1'b0, 1'b1, 1'b0, 18'h0000B);
        step(1'b0, 1'b1, 1'b0, 18'h0000C);
        check("t1_cnt3", 32'(qi.o_count), 32'd3);
        check("t1_valid_idle", 32'(qi.o_valid), 32'd0);
        step(1'b0, 1'b0, 1'b1, 18'h0);
        check_pop("t1_pop1", 18'h0000A, 2);
        step(1'b0, 1'b0, 1'b1, 18'h0);
        check_pop("t1_pop2", 18'h0000B, 1);
        step(1'b0, 1'b0, 1'b1, 18'h0);
        check_pop("t1_pop3", 18'h0000C, 0);
        check("t1_empty", 32'(qi.o_empty), 32'd1);
        step(1'b0, 1'b0, 1'b0, 18'h0);
        check("t1_valid_drop", 32'(qi.o_valid), 32'd0);
        check("t1_data_hold", 32'(qi.o_data), 32'h0000C);

        // Fill to full, overflow on the fifth push.
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 1'b0, W'(i));
        check("t2_notfull3", 32'(qi.o_full), 32'd0);
        step(1'b0, 1'b1, 1'b0, 18'd4);
        check("t2_full", 32'(qi.o_full), 32'd1);
        check("t2_cnt4", 32'(qi.o_count), 32'd4);
        check("t2_noovf", 32'(qi.o_overflow), 32'd0);
        step(1'b0, 1'b1, 1'b0, 18'd5);
        check("t2_ovf", 32'(qi.o_overflow), 32'd1);
        check("t2_cnt_stay", 32'(qi.o_count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b0, 1'b1, 18'h0);
            check_pop("t2_pop", W'(i), 4 - i);
        end
        check("t2_empty", 32'(qi.o_empty), 32'd1);
        check("t2_ovf_sticky", 32'(qi.o_overflow), 32'd1);

        // Underflow right after reset.
        step(1'b1, 1'b0, 1'b0, 18'h0);
        check("t3_ovf_clr", 32'(qi.o_overflow), 32'd0);
        step(1'b0, 1'b0, 1'b1, 18'h0);
        check("t3_unf", 32'(qi.o_underflow), 32'd1);
        check("t3_valid", 32'(qi.o_valid), 32'd0);
        check("t3_data", 32'(qi.o_data), 32'd0);
        check("t3_count", 32'(qi.o_count), 32'd0);

        // Full push+pop, then drain across the pointer wrap.
        step(1'b1, 1'b0, 1'b0, 18'h0);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, W'(i));
        step(1'b0, 1'b1, 1'b1, 18'd9);
        check_pop("t4_pp", 18'd1, 4);
        check("t4_noovf", 32'(qi.o_overflow), 32'd0);
        check("t4_full", 32'(qi.o_full), 32'd1);
        step(1'b0, 1'b0, 1'b1, 18'h0);
        check_pop("t4_pop2", 18'd2, 3);
        step(1'b0, 1'b0, 1'b1, 18'h0);
        check_pop("t4_pop3", 18'd3, 2);
        step(1'b0, 1'b0, 1'b1, 18'h0);
        check_pop("t4_pop4", 18'd4, 1);
        step(1'b0, 1'b0, 1'b1, 18'h0);
        check_pop("t4_pop9", 18'd9, 0);
        check("t4_unf", 32'(qi.o_underflow), 32'd0);

        // Empty push+pop: no fall-through.
        step(1'b0, 1'b1, 1'b1, 18'h3FFFF);
        check("t5_unf", 32'(qi.o_underflow), 32'd1);
        check("t5_count", 32'(qi.o_count), 32'd1);
        check("t5_valid", 32'(qi.o_valid), 32'd0);
        check("t5_data_hold", 32'(qi.o_data), 32'd9);
        step(1'b0, 1'b0, 1'b1, 18'h0);
        check_pop("t5_pop", 18'h3FFFF, 0);

        // Reset together with pop mid-stream.
        step(1'b0, 1'b1, 1'b0, 18'h00123);
        step(1'b0, 1'b1, 1'b0, 18'h00456);
        check("t6_cnt2", 32'(qi.o_count), 32'd2);
        step(1'b1, 1'b0, 1'b1, 18'h0);
        check("t6_count", 32'(qi.o_count), 32'd0);
        check("t6_empty", 32'(qi.o_empty), 32'd1);
        check("t6_data", 32'(qi.o_data), 32'd0);
        check("t6_valid", 32'(qi.o_valid), 32'd0);
        check("t6_unf_clr", 32'(qi.o_underflow), 32'd0);
        check("t6_ovf_clr", 32'(qi.o_overflow), 32'd0);
        step(1'b0, 1'b0, 1'b1, 18'h0);
        check("t6_pop_refused", 32'(qi.o_underflow), 32'd1);
        check("t6_pop_valid", 32'(qi.o_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
